spi_frame_tx: RTL and testbench

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

---
 rtl/spi_frame_tx.sv | 172 +++++++++++++++++
 tb/tb_spi_frame_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter: sends a parallel word LSB first with
// chip-select setup/hold/gap timing and captures MISO into rx_frame.
module spi_frame_tx #(
    parameter int FRAME_BITS = 64,
    parameter int CLK_DIV    = 2,
    parameter int CSN_SETUP  = 4,
    parameter int CSN_HOLD   = 4,
    parameter int MIN_GAP    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  spi_csn,
    input  logic                  spi_miso
);

    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int MAX_A   = (CLK_DIV > CSN_SETUP) ? CLK_DIV : CSN_SETUP;
    localparam int MAX_B   = (CSN_HOLD > MIN_GAP) ? CSN_HOLD : MIN_GAP;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx_sh;
    logic [FRAME_BITS-1:0] r_rx_sh;
    logic [FRAME_BITS-1:0] r_rx_frame;
    logic                  r_spi_clk;
    logic                  r_spi_csn;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state;
    logic [CNT_W-1:0]      w_cnt;
    logic [BIT_W-1:0]      w_bit_cnt;
    logic [FRAME_BITS-1:0] w_tx_sh;
    logic [FRAME_BITS-1:0] w_rx_sh;
    logic [FRAME_BITS-1:0] w_rx_frame;
    logic [FRAME_BITS-1:0] w_rx_ins;
    logic                  w_spi_clk;
    logic                  w_spi_csn;
    logic                  w_busy;
    logic                  w_done;

    // MISO enters at the MSB so the bit from rise k ends up at index k.
    assign w_rx_ins = (r_rx_sh >> 1) | (FRAME_BITS'(spi_miso) << (FRAME_BITS - 1));

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_tx_sh    = r_tx_sh;
        w_rx_sh    = r_rx_sh;
        w_rx_frame = r_rx_frame;
        w_spi_clk  = r_spi_clk;
        w_spi_csn  = r_spi_csn;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state   = ST_SETUP;
                    w_tx_sh   = frame;
                    w_rx_sh   = '0;
                    w_spi_csn = 1'b0;
                    w_cnt     = '0;
                    w_bit_cnt = '0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(CSN_SETUP - 1)) begin
                    w_state = ST_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                    w_cnt = '0;
                    if (!r_spi_clk) begin
                        w_spi_clk = 1'b1;
                        w_rx_sh   = w_rx_ins;
                    end else begin
                        w_spi_clk = 1'b0;
                        if (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            w_state = ST_HOLD;
                        end else begin
                            w_bit_cnt = r_bit_cnt + 1'b1;
                            w_tx_sh   = r_tx_sh >> 1;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_W'(CSN_HOLD - 1)) begin
                    w_state    = ST_GAP;
                    w_cnt      = '0;
                    w_spi_csn  = 1'b1;
                    w_done     = 1'b1;
                    w_tx_sh    = '0;
                    w_rx_frame = r_rx_sh;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(MIN_GAP - 1)) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_frame <= '0;
            r_spi_clk  <= 1'b0;
            r_spi_csn  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_tx_sh    <= w_tx_sh;
            r_rx_sh    <= w_rx_sh;
            r_rx_frame <= w_rx_frame;
            r_spi_clk  <= w_spi_clk;
            r_spi_csn  <= w_spi_csn;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // The transmit shift register LSB is the MOSI flop; it is cleared at frame end.
    assign spi_mosi = r_tx_sh[0];
    assign spi_clk  = r_spi_clk;
    assign spi_csn  = r_spi_csn;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_frame = r_rx_frame;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: a negedge SPI monitor scores each
// frame against a queue of expectations pushed when the frame is started.
module tb_spi_frame_tx;

    logic       clk;
    logic       rst;
    logic       a_start;
    logic [7:0] a_frame;
    logic       a_busy, a_done, a_clk, a_mosi, a_csn, a_miso;
    logic [7:0] a_rx;
    logic       miso_inv;

    logic       b_start;
    logic [0:0] b_frame;
    logic       b_busy, b_done, b_clk, b_mosi, b_csn;
    logic [0:0] b_rx;

    assign a_miso = miso_inv ? ~a_mosi : a_mosi;

    spi_frame_tx #(
        .FRAME_BITS(8), .CLK_DIV(2), .CSN_SETUP(3), .CSN_HOLD(3), .MIN_GAP(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(a_start), .frame(a_frame),
        .busy(a_busy), .done(a_done), .rx_frame(a_rx),
        .spi_clk(a_clk), .spi_mosi(a_mosi), .spi_csn(a_csn), .spi_miso(a_miso)
    );

    spi_frame_tx #(
        .FRAME_BITS(1), .CLK_DIV(1), .CSN_SETUP(3), .CSN_HOLD(3), .MIN_GAP(4)
    ) u_dut_edge (
        .clk(clk), .rst(rst), .start(b_start), .frame(b_frame),
        .busy(b_busy), .done(b_done), .rx_frame(b_rx),
        .spi_clk(b_clk), .spi_mosi(b_mosi), .spi_csn(b_csn), .spi_miso(b_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;
    exp_t sb_q[$];

    int         m_rises = 0, m_csn_low = 0, m_high = 0;
    int         m_done_cnt = 0, m_frames = 0, m_gap_checks = 0;
    logic [7:0] m_cap_tx = '0, m_rx_model = '0, m_prev_rx = '0;
    logic       m_prev_clk = 1'b0, m_prev_csn = 1'b1, m_prev_mosi = 1'b0;
    bit         chk_gap = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_rises     = 0;
            m_csn_low   = 0;
            m_high      = 0;
            m_prev_clk  = 1'b0;
            m_prev_csn  = 1'b1;
            m_prev_mosi = 1'b0;
            m_prev_rx   = '0;
        end else begin
            if (a_done) begin
                m_done_cnt++;
                check("done_with_csn_rise", a_csn && !m_prev_csn, 1);
            end
            if (a_csn && !m_prev_csn) begin
                exp_t e;
                m_frames++;
                check("done_at_csn_rise", a_done, 1);
                check("mosi_zero_after_frame", a_mosi, 0);
                check("sb_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("tx_bits_at_rises", m_cap_tx, e.tx);
                    check("rise_count", m_rises, 8);
                    check("csn_low_cycles", m_csn_low, 38);
                    check("rx_model", m_rx_model, e.rx);
                    check("rx_frame_at_done", a_rx, e.rx);
                end
                m_high = 0;
            end
            if (!a_csn && m_prev_csn) begin
                if (chk_gap) begin
                    check("b2b_gap", m_high, 5);
                    m_gap_checks++;
                end
                m_csn_low = 0;
                m_rises   = 0;
            end
            if (!a_csn) begin
                m_csn_low++;
                if (!m_prev_csn && !(m_prev_clk && !a_clk))
                    check("mosi_stable", a_mosi, m_prev_mosi);
                if (a_clk && !m_prev_clk) begin
                    m_rises++;
                    m_cap_tx   = {a_mosi, m_cap_tx[7:1]};
                    m_rx_model = {a_miso, m_rx_model[7:1]};
                end
            end else begin
                m_high++;
                check("clk_low_csn_high", a_clk, 0);
            end
            if (!a_done) check("rx_frame_stable", a_rx, m_prev_rx);
            m_prev_clk  = a_clk;
            m_prev_csn  = a_csn;
            m_prev_mosi = a_mosi;
            m_prev_rx   = a_rx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && a_busy; i++) step();
        check("idle_reached", a_busy, 0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && m_frames < target; i++) @(posedge clk);
        #1;
        check("frames_reached", m_frames >= target, 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int i = 0; i < budget && m_rises < target; i++) @(posedge clk);
        #1;
        check("rises_reached", m_rises >= target, 1);
    endtask

    task automatic send_frame(input logic [7:0] f, input bit inv);
        miso_inv = inv;
        a_frame  = f;
        a_start  = 1'b1;
        sb_q.push_back('{tx: f, rx: (inv ? ~f : f)});
        step();
        a_start = 1'b0;
        check("csn_low_after_start", a_csn, 0);
        check("mosi_first_bit", a_mosi, f[0]);
        check("busy_after_start", a_busy, 1);
        check("clk_low_in_setup", a_clk, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        a_start  = 1'b0;
        a_frame  = '0;
        miso_inv = 1'b0;
        b_start  = 1'b0;
        b_frame  = '0;
        repeat (3) step();
        check("rst_csn", a_csn, 1);
        check("rst_clk", a_clk, 0);
        check("rst_mosi", a_mosi, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_rx_frame", a_rx, 0);
        check("rst_edge_csn", b_csn, 1);
        rst = 1'b0;
        step();

        // Basic send
        send_frame(8'hA5, 1'b0);
        wait_frames(1, 200);
        check("basic_done_count", m_done_cnt, 1);

        // Loopback and inverted MISO
        wait_idle(50);
        send_frame(8'h3C, 1'b0);
        wait_frames(2, 200);
        check("loopback_rx_frame", a_rx, 8'h3C);
        check("loopback_rx_model", m_rx_model, 8'h3C);
        wait_idle(50);
        send_frame(8'h96, 1'b1);
        wait_frames(3, 200);
        check("inverted_rx_frame", a_rx, 8'h69);

        // Busy rejection: start and frame change during SHIFT
        wait_idle(50);
        send_frame(8'h01, 1'b0);
        wait_rises(2, 100);
        a_frame = 8'hFF;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        wait_frames(4, 200);
        repeat (30) step();
        check("no_second_frame", m_frames, 4);
        check("reject_busy_low", a_busy, 0);
        check("reject_done_count", m_done_cnt, 4);

        // Back-to-back with start held high
        wait_idle(50);
        miso_inv = 1'b0;
        a_frame  = 8'h55;
        for (int i = 0; i < 3; i++) sb_q.push_back('{tx: 8'h55, rx: 8'h55});
        a_start = 1'b1;
        step();
        step();
        chk_gap = 1'b1;
        wait_frames(7, 400);
        a_start = 1'b0;
        chk_gap = 1'b0;
        wait_idle(50);
        repeat (20) step();
        check("b2b_frames", m_frames, 7);
        check("b2b_gap_checks", m_gap_checks, 2);
        check("b2b_done_count", m_done_cnt, 7);

        // Reset mid-frame, with start held during reset
        send_frame(8'hC3, 1'b0);
        wait_rises(3, 200);
        rst     = 1'b1;
        a_start = 1'b1;
        sb_q.delete();
        step();
        check("midrst_csn", a_csn, 1);
        check("midrst_clk", a_clk, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        check("midrst_rx_frame", a_rx, 0);
        step();
        rst     = 1'b0;
        a_start = 1'b0;
        step();
        check("start_ignored_in_rst", a_busy, 0);
        repeat (20) step();
        check("midrst_no_done", m_done_cnt, 7);
        check("midrst_no_frame", m_frames, 7);
        check("midrst_rx_held", a_rx, 0);

        // Edge parameters: one-bit frame, CLK_DIV=1
        begin
            int   lows = 0, rises = 0, dones = 0;
            logic pc = 1'b0, rm = 1'b0;
            b_frame = 1'b1;
            b_start = 1'b1;
            for (int i = 0; i < 40; i++) begin
                step();
                b_start = 1'b0;
                if (!b_csn) lows++;
                if (b_clk && !pc) begin
                    rises++;
                    rm = b_mosi;
                end
                pc = b_clk;
                if (b_done) dones++;
            end
            check("edge_rises", rises, 1);
            check("edge_csn_low", lows, 8);
            check("edge_done_count", dones, 1);
            check("edge_mosi_at_rise", rm, 1);
            check("edge_rx_frame", b_rx, 1);
            check("edge_idle", b_busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
